// File: rtl/kgp_sub_seq.sv
// Multi-cycle add/subtract: kill/generate/propagate carries resolved by recursive
// doubling, one level per clock through a shared per-position combine stage.
module kgp_sub_seq_cell (
  input  logic [1:0] k,
  input  logic [1:0] far,
  output logic [1:0] nxt
);
  // A propagate inherits the code from s positions below; kill/generate are final.
  assign nxt = (k == 2'b01) ? far : k;
endmodule

module kgp_sub_seq #(
  parameter int W      = 16,
  parameter int LEVELS = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         c_out,
  output logic         ovf
);
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) + 1 : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [W:0][1:0]     k_q, k_d, k_step;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic [W-1:0]        a_q, a_d, bb_q, bb_d, d_q, d_d;
  logic                c_q, c_d, ovf_q, ovf_d, ov_q, ov_d;
  logic [W-1:0]        b_eff;
  logic [W:0]          carry;

  assign b_eff = op_sub ? ~b : b;

  // Per-position operand select for the current stride s = 2^lvl.
  for (genvar i = 0; i <= W; i++) begin : g_pos
    logic [1:0] far;
    always_comb begin
      far = k_q[i];
      for (int l = 0; l < LEVELS; l++)
        if (lvl_q == LW'(l) && i >= (1 << l))
          far = k_q[(i >= (1 << l)) ? i - (1 << l) : i];
    end
    kgp_sub_seq_cell u_cell (.k(k_q[i]), .far(far), .nxt(k_step[i]));
    assign carry[i] = (k_q[i] == 2'b11);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    lvl_d   = lvl_q;
    a_d     = a_q;
    bb_d    = bb_q;
    d_d     = d_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        bb_d    = b_eff;
        k_d[0]  = op_sub ? 2'b11 : 2'b00;
        for (int i = 0; i < W; i++)
          k_d[i+1] = {a[i] & b_eff[i], a[i] | b_eff[i]};
        lvl_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        k_d   = k_step;
        lvl_d = lvl_q + LW'(1);
        if (lvl_q == LW'(LEVELS - 1)) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle registers the result; afterwards wait for the consumer.
        if (!ov_q) begin
          d_d   = a_q ^ bb_q ^ carry[W-1:0];
          c_d   = carry[W];
          ovf_d = carry[W] ^ carry[W-1];
          ov_d  = 1'b1;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      lvl_q   <= '0;
      a_q     <= '0;
      bb_q    <= '0;
      d_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lvl_q   <= lvl_d;
      a_q     <= a_d;
      bb_q    <= bb_d;
      d_q     <= d_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = ov_q;
  assign d         = d_q;
  assign c_out     = c_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_kgp_sub_seq.sv
// Directed-vector bench for kgp_sub_seq: table of operations plus backpressure and reset sequences.
module tb_kgp_sub_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] d;
  logic        c_out, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] d;
    logic        c;
    logic        o;
  } vec_t;
  vec_t tbl[10];

  kgp_sub_seq #(.W(16), .LEVELS(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one op, check latency and result, then drain it with out_ready=1.
  task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                        input logic ts, input logic [15:0] ed, input logic ec, input logic eo,
                        input bit drain);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, " in_ready"}, in_ready, 1'b1);
    a = ta; b = tb; op_sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ta ^ 16'h5a5a; op_sub = ~ts;   // garbage after accept must not matter
    n = 0;
    while (n < 20) begin
      n++;
      if (out_valid) break;
      @(posedge clk); #1;
    end
    // n counts edges since accept, offset by the first pre-edge test
    chk({nm, " latency"}, n - 1, 6);
    chk({nm, " d"}, d, ed);
    chk({nm, " c_out"}, c_out, ec);
    chk({nm, " ovf"}, ovf, eo);
    chk({nm, " in_ready busy"}, in_ready, 1'b0);
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " out_valid drop"}, out_valid, 1'b0);
      chk({nm, " in_ready back"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    tbl[0] = '{16'h1234, 16'h0034, 1'b1, 16'h1200, 1'b1, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    tbl[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[9] = '{16'h0005, 16'h8000, 1'b1, 16'h8005, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst d", d, 16'h0);
    chk("rst c_out", c_out, 1'b0);
    chk("rst ovf", ovf, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst in_ready", in_ready, 1'b1);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub,
             tbl[i].d, tbl[i].c, tbl[i].o, 1'b1);

    // Backpressure: hold the result for 4 cycles while stray in_valid pulses arrive
    run_op("bp", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2 == 0); a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp%0d out_valid", i), out_valid, 1'b1);
      chk($sformatf("bp%0d d", i), d, 16'h8000);
      chk($sformatf("bp%0d c_out", i), c_out, 1'b0);
      chk($sformatf("bp%0d ovf", i), ovf, 1'b1);
      chk($sformatf("bp%0d in_ready", i), in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release out_valid", out_valid, 1'b0);
    chk("bp release in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp idle%0d out_valid", i), out_valid, 1'b0);
    end

    // Reset during the 3rd BUSY cycle; previous result (8000,0,1) must be wiped
    a = 16'h1234; b = 16'h0034; op_sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", out_valid, 1'b0);
    chk("mid-rst d", d, 16'h0);
    chk("mid-rst c_out", c_out, 1'b0);
    chk("mid-rst ovf", ovf, 1'b0);
    chk("mid-rst in_ready", in_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("after-rst%0d out_valid", i), out_valid, 1'b0);
      chk($sformatf("after-rst%0d in_ready", i), in_ready, 1'b1);
    end
    run_op("rst-sub00", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
